// File: rtl/smg_time_counter.sv
// smg_time_counter: one-second prescaler and BCD HH:MM:SS counter with a button-driven set mode.
module smg_time_counter #(
    parameter int CLK_DIV = 50_000_000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Set_Sel,
    input  logic        Set_Inc,
    output logic [23:0] Digit_Data,
    output logic [5:0]  Blink_Mask,
    output logic        Sec_Tick,
    output logic        Set_Active
);
    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);
    typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN, SET_SEC} state_t;
    state_t state, state_n;
    logic [PW-1:0] presc, presc_n;
    logic [7:0] hour, min, sec, hour_n, min_n, sec_n;
    logic sel_prev, inc_prev, sel_edge, inc_edge, tick;
    function automatic logic [7:0] inc_bcd(input logic [7:0] v, input logic [7:0] top);
        return (v == top) ? 8'h00 : (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction
    assign sel_edge = Set_Sel & ~sel_prev;
    assign inc_edge = Set_Inc & ~inc_prev;
    assign Digit_Data = {hour, min, sec};
    // A select edge in RUN wins over a pending tick and restarts the second.
    always_comb begin
        tick = state == RUN && !sel_edge && presc == LAST;
        presc_n = (state == RUN && !sel_edge && presc != LAST) ? presc + PW'(1) : '0;
        state_n = !sel_edge ? state : state == RUN ? SET_HOUR : state == SET_HOUR ? SET_MIN :
                  state == SET_MIN ? SET_SEC : RUN;
        sec_n = (tick || (inc_edge && state == SET_SEC)) ? inc_bcd(sec, 8'h59) : sec;
        min_n = ((tick && sec == 8'h59) || (inc_edge && state == SET_MIN)) ? inc_bcd(min, 8'h59) : min;
        hour_n = ((tick && sec == 8'h59 && min == 8'h59) || (inc_edge && state == SET_HOUR)) ?
                 inc_bcd(hour, 8'h23) : hour;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= RUN;
            presc <= '0;
            hour <= '0;
            min <= '0;
            sec <= '0;
            sel_prev <= 1'b1;
            inc_prev <= 1'b1;
            Sec_Tick <= 1'b0;
            Blink_Mask <= '0;
            Set_Active <= 1'b0;
        end else begin
            state <= state_n;
            presc <= presc_n;
            hour <= hour_n;
            min <= min_n;
            sec <= sec_n;
            sel_prev <= Set_Sel;
            inc_prev <= Set_Inc;
            Sec_Tick <= tick;
            Blink_Mask <= state_n == SET_HOUR ? 6'b110000 : state_n == SET_MIN ? 6'b001100 :
                          state_n == SET_SEC ? 6'b000011 : 6'b000000;
            Set_Active <= state_n != RUN;
        end
    end
endmodule

// File: tb/tb_smg_time_counter.sv
// tb_smg_time_counter: directed checks of ticking, carry, set mode, edge detection and reset.
module tb_smg_time_counter;
    logic CLK = 1'b0, RST = 1'b1, Set_Sel = 1'b0, Set_Inc = 1'b0;
    logic [23:0] Digit_Data;
    logic [5:0] Blink_Mask;
    logic Sec_Tick, Set_Active;
    int n_run = 0, n_fail = 0;
    logic tick_seen;
    smg_time_counter #(.CLK_DIV(10)) dut (
        .CLK(CLK), .RST(RST), .Set_Sel(Set_Sel), .Set_Inc(Set_Inc),
        .Digit_Data(Digit_Data), .Blink_Mask(Blink_Mask), .Sec_Tick(Sec_Tick), .Set_Active(Set_Active)
    );
    always #5 CLK = ~CLK;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step(input int n);
        repeat (n) begin
            @(negedge CLK);
            tick_seen |= Sec_Tick;
        end
    endtask
    task automatic press_sel();
        Set_Sel = 1'b1;
        step(1);
        Set_Sel = 1'b0;
        step(1);
    endtask
    task automatic press_inc(input int n);
        repeat (n) begin
            Set_Inc = 1'b1;
            step(1);
            Set_Inc = 1'b0;
            step(1);
        end
    endtask
    initial begin
        int first, count, bad;
        logic [23:0] d10;
        tick_seen = 1'b0;
        first = 0; count = 0; bad = 0; d10 = '0;
        step(2);
        RST = 1'b0;
        check("rst_digits", Digit_Data, 24'h000000);
        check("rst_blink", Blink_Mask, 6'b000000);
        check("rst_active", Set_Active, 0);
        check("rst_tick", Sec_Tick, 0);
        for (int i = 1; i <= 600; i++) begin
            step(1);
            if (Sec_Tick !== (i % 10 == 0)) bad++;
            if (Sec_Tick === 1'b1) begin
                count++;
                if (first == 0) first = i;
            end
            if (i == 10) d10 = Digit_Data;
        end
        check("tick_first_edge", first, 10);
        check("tick_count", count, 60);
        check("tick_period_errs", bad, 0);
        check("digits_at_first_tick", d10, 24'h000001);
        check("digits_600", Digit_Data, 24'h000100);
        press_sel();
        check("blink_hour", Blink_Mask, 6'b110000);
        check("active_hour", Set_Active, 1);
        press_inc(23);
        press_sel();
        check("blink_min", Blink_Mask, 6'b001100);
        press_inc(58);
        press_sel();
        check("blink_sec", Blink_Mask, 6'b000011);
        press_inc(58);
        check("set_235958", Digit_Data, 24'h235958);
        press_sel();
        check("back_run", Set_Active, 0);
        step(8);
        check("pre_tick1", Sec_Tick, 0);
        step(1);
        check("tick1", Sec_Tick, 1);
        check("time_235959", Digit_Data, 24'h235959);
        step(9);
        check("pre_tick2", Sec_Tick, 0);
        step(1);
        check("tick2", Sec_Tick, 1);
        check("wrap_midnight", Digit_Data, 24'h000000);
        tick_seen = 1'b0;
        press_sel();
        press_inc(25);
        check("hour_25inc", Digit_Data, 24'h010000);
        check("hour_blink", Blink_Mask, 6'b110000);
        check("no_tick_in_set", tick_seen, 0);
        press_sel();
        press_sel();
        press_sel();
        check("run_again", Set_Active, 0);
        Set_Sel = 1'b1;
        step(50);
        check("hold_one_advance", Blink_Mask, 6'b110000);
        check("hold_active", Set_Active, 1);
        Set_Sel = 1'b0;
        step(1);
        Set_Sel = 1'b1;
        RST = 1'b1;
        step(1);
        RST = 1'b0;
        check("rst_clears_time", Digit_Data, 24'h000000);
        step(5);
        check("held_through_rst", Set_Active, 0);
        check("held_through_rst_blink", Blink_Mask, 6'b000000);
        Set_Sel = 1'b0;
        step(1);
        press_sel();
        press_sel();
        press_inc(3);
        press_sel();
        press_inc(59);
        check("set_000359", Digit_Data, 24'h000359);
        Set_Sel = 1'b1;
        Set_Inc = 1'b1;
        step(1);
        Set_Sel = 1'b0;
        Set_Inc = 1'b0;
        check("simul_wrap_no_carry", Digit_Data, 24'h000300);
        check("simul_to_run", Set_Active, 0);
        check("simul_blink", Blink_Mask, 6'b000000);
        step(9);
        check("simul_pre_tick", Sec_Tick, 0);
        step(1);
        check("simul_tick", Sec_Tick, 1);
        check("simul_tick_time", Digit_Data, 24'h000301);
        press_sel();
        press_inc(12);
        press_sel();
        press_inc(31);
        press_sel();
        press_inc(55);
        press_sel();
        press_sel();
        press_sel();
        check("set_123456", Digit_Data, 24'h123456);
        check("in_set_min", Blink_Mask, 6'b001100);
        RST = 1'b1;
        step(1);
        RST = 1'b0;
        check("midrst_digits", Digit_Data, 24'h000000);
        check("midrst_blink", Blink_Mask, 6'b000000);
        check("midrst_active", Set_Active, 0);
        check("midrst_tick", Sec_Tick, 0);
        press_inc(1);
        check("inc_ignored_run", Digit_Data, 24'h000000);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
